alu_issue_seq: RTL and testbench

Instruction-side driver for the 8-bit ALU subsystem (ALU control plus 8-bit ALU). Accepts 32-bit RISC-V instruction words over a valid/ready handshake and reads operands from an internal 32×8 register file. It decodes `aluop` and `funcCode` for the ALU, captures the combinational result and flags, writes back `rd`, and returns a per-instruction response over a second valid/ready handshake. It is the initiator that exercises the ALU top as a small multi-cycle datapath.

---
 rtl/alu_issue_pkg.sv | 64 ++++++
 rtl/alu_issue_seq_regfile.sv | 45 ++++
 rtl/alu_issue_seq.sv | 142 ++++++++++++++
 tb/tb_alu_issue_seq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared constants, FSM encoding and decoder for the ALU issue sequencer
//
// Contents:
//   OP_R / OP_IMM / OP_BR          RISC-V major opcodes handled by the sequencer
//   ALUOP_ADD / ALUOP_SUB / ALUOP_FUNC  aluop encodings driven to the ALU control
//   state_t                        sequencer FSM states (IDLE, EXEC, RESP)
//   dec_t / decode()               per-instruction control decoded at accept time

package alu_issue_pkg;

  localparam int REG_AW = 5;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Control bits needed after accept; everything else comes from the ALU.
  typedef struct packed {
    logic [1:0] aluop;
    logic [9:0] func;
    logic       use_imm;
    logic       wen;
    logic       br;
    logic       err;
  } dec_t;

  // Illegal opcodes still produce a defined ALU drive (add of rs1/rs2);
  // the result is discarded by the err path.
  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d = '0;
    case (instr[6:0])
      OP_R: begin
        d.aluop = ALUOP_FUNC;
        d.func  = {instr[31:25], instr[14:12]};
        d.wen   = 1'b1;
      end
      OP_IMM: begin
        d.aluop   = ALUOP_ADD;
        d.use_imm = 1'b1;
        d.wen     = 1'b1;
      end
      OP_BR: begin
        d.aluop = ALUOP_SUB;
        d.br    = 1'b1;
      end
      default: begin
        d.err = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_seq_regfile.sv
// rtl/alu_issue_seq_regfile.sv - NREGS x XLEN register file with x0 hardwired to zero
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high clear of all entries
//   ra1/rd1, ra2/rd2  combinational operand read ports
//   dbg_addr/dbg_data combinational debug read port
//   we, wa, wd        synchronous write port; writes to x0 are dropped

module alu_regfile
  import alu_issue_pkg::*;
#(
  parameter int XLEN  = 8,
  parameter int NREGS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_AW-1:0]   ra1,
  output logic [XLEN-1:0]     rd1,
  input  logic [REG_AW-1:0]   ra2,
  output logic [XLEN-1:0]     rd2,
  input  logic [REG_AW-1:0]   dbg_addr,
  output logic [XLEN-1:0]     dbg_data,
  input  logic                we,
  input  logic [REG_AW-1:0]   wa,
  input  logic [XLEN-1:0]     wd
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // x0 is forced on the read side too, so its storage never matters.
  assign rd1      = (ra1 == '0)      ? '0 : regs[ra1];
  assign rd2      = (ra2 == '0)      ? '0 : regs[ra2];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - three-state instruction issue sequencer driving an external 8-bit ALU
//
// Ports:
//   clk, reset                       rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_instr       32-bit RISC-V instruction handshake
//   alu_aluop/alu_funcCode/alu_a/b   registered drive to the ALU top
//   alu_result/zero/carryout/overflow combinational ALU response
//   out_valid/out_ready              per-instruction response handshake
//   out_rd/result/zero/carry/ovf/taken/err  captured response fields
//   dbg_addr/dbg_data                combinational register-file debug read

module alu_issue_seq
  import alu_issue_pkg::*;
#(
  parameter int XLEN  = 8,
  parameter int NREGS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  output logic [1:0]          alu_aluop,
  output logic [9:0]          alu_funcCode,
  output logic [XLEN-1:0]     alu_a,
  output logic [XLEN-1:0]     alu_b,
  input  logic [XLEN-1:0]     alu_result,
  input  logic                alu_zero,
  input  logic                alu_carryout,
  input  logic                alu_overflow,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [REG_AW-1:0]   out_rd,
  output logic [XLEN-1:0]     out_result,
  output logic                out_zero,
  output logic                out_carry,
  output logic                out_ovf,
  output logic                out_taken,
  output logic                out_err,
  input  logic [REG_AW-1:0]   dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  state_t            state;
  dec_t              dec;
  logic [XLEN-1:0]   rf_rd1;
  logic [XLEN-1:0]   rf_rd2;
  logic              rf_we;
  logic [REG_AW-1:0] rd_q;
  logic              wen_q;
  logic              br_q;
  logic              err_q;

  assign dec = decode(in_instr);

  // in_ready is gated by reset directly so nothing can be accepted on the
  // reset edge itself.
  assign in_ready = (state == IDLE) & ~reset;

  // The write lands on the EXEC edge, so the next instruction (accepted no
  // earlier than two edges later) reads the new value without forwarding.
  assign rf_we = (state == EXEC) & wen_q;

  alu_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .ra1      (in_instr[19:15]),
    .rd1      (rf_rd1),
    .ra2      (in_instr[24:20]),
    .rd2      (rf_rd2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .wa       (rd_q),
    .wd       (alu_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      alu_aluop    <= '0;
      alu_funcCode <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      rd_q         <= '0;
      wen_q        <= 1'b0;
      br_q         <= 1'b0;
      err_q        <= 1'b0;
      out_valid    <= 1'b0;
      out_rd       <= '0;
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_carry    <= 1'b0;
      out_ovf      <= 1'b0;
      out_taken    <= 1'b0;
      out_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Operands are sampled here and held on the ALU ports until
            // the next accept.
            alu_aluop    <= dec.aluop;
            alu_funcCode <= dec.func;
            alu_a        <= rf_rd1;
            alu_b        <= dec.use_imm ? in_instr[20 +: XLEN] : rf_rd2;
            rd_q         <= in_instr[11:7];
            wen_q        <= dec.wen;
            br_q         <= dec.br;
            err_q        <= dec.err;
            state        <= EXEC;
          end
        end
        EXEC: begin
          out_rd     <= wen_q ? rd_q : '0;
          out_result <= err_q ? '0 : alu_result;
          out_zero   <= ~err_q & alu_zero;
          out_carry  <= ~err_q & alu_carryout;
          out_ovf    <= ~err_q & alu_overflow;
          out_taken  <= br_q & alu_zero;
          out_err    <= err_q;
          out_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - scoreboard bench for alu_issue_seq with a behavioural 8-bit ALU

module tb_alu_issue_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [1:0]  alu_aluop;
  logic [9:0]  alu_funcCode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_result;
  logic        alu_zero;
  logic        alu_carryout;
  logic        alu_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [7:0]  out_result;
  logic        out_zero;
  logic        out_carry;
  logic        out_ovf;
  logic        out_taken;
  logic        out_err;
  logic [4:0]  dbg_addr;
  logic [7:0]  dbg_data;

  always #5 clk = ~clk;

  alu_issue_seq #(.XLEN(8), .NREGS(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .alu_aluop    (alu_aluop),
    .alu_funcCode (alu_funcCode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_carryout (alu_carryout),
    .alu_overflow (alu_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rd       (out_rd),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_carry    (out_carry),
    .out_ovf      (out_ovf),
    .out_taken    (out_taken),
    .out_err      (out_err),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  // ALU top stand-in: subtraction is a + ~b + 1, carry is the raw carry-out.
  logic [8:0] alu_sum;
  logic       alu_is_sub;
  always_comb begin
    alu_sum    = '0;
    alu_is_sub = 1'b0;
    alu_result = '0;
    case (alu_aluop)
      2'b00: alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01: begin
        alu_is_sub = 1'b1;
        alu_sum    = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
      end
      2'b10: begin
        case (alu_funcCode)
          10'b0000000_000: alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
          10'b0100000_000: begin
            alu_is_sub = 1'b1;
            alu_sum    = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
          end
          10'b0000000_111: alu_sum = {1'b0, alu_a & alu_b};
          10'b0000000_110: alu_sum = {1'b0, alu_a | alu_b};
          default:         alu_sum = '0;
        endcase
      end
      default: alu_sum = '0;
    endcase
    alu_result = alu_sum[7:0];
  end
  assign alu_zero     = (alu_result == 8'h00);
  assign alu_carryout = alu_sum[8];
  assign alu_overflow = alu_is_sub ? ((alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]))
                                   : ((alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]));

  typedef struct {
    logic [4:0] rd;
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       ovf;
    logic       taken;
    logic       err;
  } resp_t;

  resp_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  logic [1:0] last_aluop;
  logic [9:0] last_func;
  logic [7:0] last_a;
  logic [7:0] last_b;
  logic [7:0] exp_regs [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic resp_t mk(input logic [4:0] rd, input logic [7:0] res, input logic z,
                               input logic c, input logic o, input logic t, input logic e);
    resp_t r;
    r.rd = rd; r.result = res; r.zero = z; r.carry = c; r.ovf = o; r.taken = t; r.err = e;
    return r;
  endfunction

  function automatic logic [31:0] out_snapshot();
    return {12'd0, out_valid, out_rd, out_result, out_zero, out_carry, out_ovf, out_taken, out_err};
  endfunction

  task automatic chk_reg(input logic [4:0] a, input logic [7:0] v);
    dbg_addr = a;
    #1;
    check($sformatf("x%0d", a), {24'd0, dbg_data}, {24'd0, v});
  endtask

  task automatic chk_regs();
    for (int i = 0; i < 8; i++) chk_reg(i[4:0], exp_regs[i]);
  endtask

  // Issues one instruction, checks 2-sample latency and the response.
  // hold > 0 keeps out_ready low that many cycles while offering a stray instruction.
  task automatic issue(input logic [31:0] instr, input resp_t e, input int hold);
    int    n;
    resp_t r;
    logic [31:0] snap;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    out_ready = (hold == 0);
    in_instr  = instr;
    in_valid  = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("exec_valid_low", {31'd0, out_valid}, 0);
    @(negedge clk);
    check("valid_latency", {31'd0, out_valid}, 1);
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      check("resp_timeout", 0, 1);
      void'(sb.pop_front());
      out_ready = 1'b1;
      return;
    end
    r = sb.pop_front();
    check("rd",     {27'd0, out_rd},     {27'd0, r.rd});
    check("result", {24'd0, out_result}, {24'd0, r.result});
    check("zero",   {31'd0, out_zero},   {31'd0, r.zero});
    check("carry",  {31'd0, out_carry},  {31'd0, r.carry});
    check("ovf",    {31'd0, out_ovf},    {31'd0, r.ovf});
    check("taken",  {31'd0, out_taken},  {31'd0, r.taken});
    check("err",    {31'd0, out_err},    {31'd0, r.err});
    last_aluop = alu_aluop;
    last_func  = alu_funcCode;
    last_a     = alu_a;
    last_b     = alu_b;
    if (hold > 0) begin
      snap = out_snapshot();
      for (int i = 0; i < hold; i++) begin
        in_instr = 32'h0090_0393;
        in_valid = 1'b1;
        @(negedge clk);
        check("hold_stable", out_snapshot(), snap);
        check("hold_in_ready", {31'd0, in_ready}, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b1;
    dbg_addr  = '0;
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 0);
    check("rst_outs", out_snapshot(), 0);
    check("rst_alu", {10'd0, alu_aluop, alu_funcCode, alu_a, alu_b}, 0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 1);
    chk_reg(5'd1, 8'h00);

    issue(32'h0640_0093, mk(5'd1, 8'h64, 0, 0, 0, 0, 0), 0);
    chk_reg(5'd1, 8'h64);
    issue(32'hFC80_0113, mk(5'd2, 8'hC8, 0, 0, 0, 0, 0), 0);
    issue(32'h0020_81B3, mk(5'd3, 8'h2C, 0, 1, 0, 0, 0), 0);
    check("add_aluop", {30'd0, last_aluop}, 2);
    check("add_func",  {22'd0, last_func},  0);
    check("add_a",     {24'd0, last_a},     32'h64);
    check("add_b",     {24'd0, last_b},     32'hC8);
    chk_reg(5'd3, 8'h2C);
    issue(32'h07F0_0293, mk(5'd5, 8'h7F, 0, 0, 0, 0, 0), 0);
    issue(32'h0052_8333, mk(5'd6, 8'hFE, 0, 0, 1, 0, 0), 0);
    issue(32'h4010_8233, mk(5'd4, 8'h00, 1, 1, 0, 0, 0), 0);
    exp_regs[1] = 8'h64; exp_regs[2] = 8'hC8; exp_regs[3] = 8'h2C;
    exp_regs[4] = 8'h00; exp_regs[5] = 8'h7F; exp_regs[6] = 8'hFE;
    chk_regs();
    issue(32'h0010_8063, mk(5'd0, 8'h00, 1, 1, 0, 1, 0), 0);
    check("beq_aluop", {30'd0, last_aluop}, 1);
    chk_regs();
    issue(32'h0050_0013, mk(5'd0, 8'h05, 0, 0, 0, 0, 0), 0);
    chk_reg(5'd0, 8'h00);
    issue(32'h0000_007F, mk(5'd0, 8'h00, 0, 0, 0, 0, 1), 5);
    chk_regs();
    check("sb_empty", sb.size(), 0);

    // Reset while addi x7 is in EXEC.
    @(negedge clk);
    while (!in_ready) @(negedge clk);
    in_instr = 32'h0090_0393;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    check("exec_rst_in_ready", {31'd0, in_ready}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("exec_rst_ready_back", {31'd0, in_ready}, 1);
    for (int i = 0; i < 4; i++) begin
      check("exec_rst_no_valid", {31'd0, out_valid}, 0);
      @(negedge clk);
    end
    chk_reg(5'd7, 8'h00);
    chk_reg(5'd1, 8'h00);

    issue(32'h0090_0393, mk(5'd7, 8'h09, 0, 0, 0, 0, 0), 0);
    chk_reg(5'd7, 8'h09);
    check("sb_empty_end", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
